// File: rtl/main_mem_responder.sv
// Pipelined main-memory responder for data-cache fills and writebacks.
// Optional write-ack pipeline slot: define MAIN_MEM_WRITE_ACK_EN.
module main_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
`ifdef MAIN_MEM_WRITE_ACK_EN
  ,
  output logic                  wr_ack
`endif
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 1);

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [ADDR_WIDTH-2:0] idx;
  logic                  addr_lsb_unused;
  logic                  rd_req;
  logic                  wr_req;
  logic                  we;

  logic [LATENCY-1:0]    rv;
  logic [DATA_WIDTH-1:0] rd [LATENCY];

  assign idx             = addr[ADDR_WIDTH-1:1];
  assign addr_lsb_unused = addr[0];
  assign rd_req          = enable && !wr;
  assign wr_req          = enable && wr;
  // Writes presented during reset are dropped.
  assign we              = wr_req && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= data_in;
    end
  end

  // Read data is captured at issue, so later writes never alter it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rd[i] <= '0;
      end
    end else begin
      rv[0] <= rd_req;
      rd[0] <= rd_req ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        rv[i] <= rv[i-1];
        rd[i] <= rd[i-1];
      end
    end
  end

  assign data_valid = rv[LATENCY-1];
  assign data_out   = rd[LATENCY-1];

`ifdef MAIN_MEM_WRITE_ACK_EN
  logic [LATENCY-1:0] wv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv <= '0;
    end else begin
      wv[0] <= wr_req;
      for (int i = 1; i < LATENCY; i++) begin
        wv[i] <= wv[i-1];
      end
    end
  end

  assign wr_ack = wv[LATENCY-1];
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder at LATENCY=4.
// Vector table plus hand sequences for bursts, bubbles and reset.
module tb_main_mem_responder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
`ifdef MAIN_MEM_WRITE_ACK_EN
  logic        wr_ack;
`endif

  int total;
  int bad;

  main_mem_responder #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .wr(wr),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .data_valid(data_valid)
`ifdef MAIN_MEM_WRITE_ACK_EN
    ,
    .wr_ack(wr_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        ev;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic w,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic ev, input logic [15:0] ed,
                      input string nm);
    @(negedge clk);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, {15'd0, data_valid}, {15'd0, ev});
    chk({nm, ".data"}, data_out, ed);
  endtask

  logic        bp [6];
  logic [15:0] ba [6];
  logic [15:0] bd [6];

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;

    tbl[0]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222};
    tbl[13] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 16'h0000};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222};

    bp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ba = '{16'h0010, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h1002};
    bd = '{16'hBEEF, 16'h0, 16'h2222, 16'h0, 16'h0, 16'hA001};

    #12;
    chk("reset.valid", {15'd0, data_valid}, 16'd0);
    chk("reset.data", data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].en, tbl[i].w, tbl[i].a, tbl[i].d,
           tbl[i].ev, tbl[i].ed, $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 16'h1000 + 16'(2 * k), 16'hA000 + 16'(k),
           1'b0, 16'h0, $sformatf("preload%0d", k));
    end
    for (int k = 0; k < 12; k++) begin
      logic        ev;
      logic [15:0] ed;
      ev = (k >= 3) && (k < 11);
      ed = ev ? 16'hA000 + 16'(k - 3) : 16'h0000;
      step(k < 8, 1'b0, 16'h1000 + 16'(2 * k), 16'h0, ev, ed,
           $sformatf("burst%0d", k));
    end

    for (int k = 0; k < 9; k++) begin
      logic        en;
      logic        ev;
      logic [15:0] ed;
      en = (k < 6) ? bp[k] : 1'b0;
      ev = (k >= 3) ? bp[k-3] : 1'b0;
      ed = ev ? bd[k-3] : 16'h0000;
      step(en, 1'b0, (k < 6) ? ba[k] : 16'h0, 16'h0, ev, ed,
           $sformatf("bubble%0d", k));
    end

    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, "rstq0");
    step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, "rstq1");
    step(1'b1, 1'b0, 16'h1002, 16'h0, 1'b0, 16'h0, "rstq2");
    step(1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'hBEEF, "rstq3");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async.valid", {15'd0, data_valid}, 16'd0);
    chk("rst_async.data", data_out, 16'h0000);
    @(negedge clk);
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = 16'h0010;
    data_in = 16'hDEAD;
    @(posedge clk);
    #1;
    chk("rst_held.valid", {15'd0, data_valid}, 16'd0);
    chk("rst_held.data", data_out, 16'h0000);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    wr     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
           $sformatf("nostale%0d", k));
    end
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, "retain0");
    step(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 16'h0, "retain1");
    step(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 16'h0, "retain2");
    step(1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'hBEEF, "retain3");

`ifdef MAIN_MEM_WRITE_ACK_EN
    begin
      logic        aw [7];
      logic        ar [7];
      logic [15:0] ad [7];
      aw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ar = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ad = '{16'h4444, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0};
      for (int k = 0; k < 7; k++) begin
        logic ea;
        logic ev;
        ea = (k == 3) || (k == 5);
        ev = (k == 4);
        step(aw[k] || ar[k], aw[k], 16'h0040, ad[k], ev,
             ev ? 16'h4444 : 16'h0, $sformatf("ack%0d", k));
        chk($sformatf("ack%0d.wr_ack", k), {15'd0, wr_ack},
            {15'd0, ea});
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
